operand_loader: RTL and testbench
=================================

Name: operand_loader

Overview:
- Upstream stage of the board-level 4-bit ripple-carry adder.
- Takes raw slide switches and one active-low pushbutton, then synchronises and debounces them.
- Captures operand A and then operand B on successive presses.
- Holds both operands stable on data_a/data_b, with a valid flag, so the adder's combinational sum and carry LEDs show a settled result.

Parameters:
- WIDTH, 4, operand width; equals the adder's WIDTH.
- DB_CYCLES, 500000, number of consecutive stable clk cycles required before the debounced button level changes (10 ms at 50 MHz); minimum 2.

Ports:
- clk  input  1  system clock; the single clock domain.
- rst_n  input  1  asynchronous, active-low reset.
- sw  input  WIDTH  raw slide switches; asynchronous to clk.
- btn_n  input  1  raw pushbutton; low = pressed; asynchronous and bouncing.
- data_a  output  WIDTH  captured operand A; drives the adder's data_a.
- data_b  output  WIDTH  captured operand B; drives the adder's data_b.
- valid  output  1  high while both operands form a completed pair.
- state_led  output  2  current FSM state, for LED display.

Behaviour:
- Clocking and reset:
  - One clock domain, clk.
  - Reset is asynchronous and active-low: rst_n asserts immediately, and deassertion is sampled on clk.
- Reset values:
  - data_a = 0, data_b = 0, valid = 0.
  - state = WAIT_A, so state_led = 2'b00.
  - Synchroniser flops = 1 for btn and 0 for sw.
  - Debounced button level = 1 (released); debounce counter = 0.
- Synchronisation:
  - btn_n and each sw bit pass through a 2-flop synchroniser.
  - sw is not debounced. It is sampled from its synchronised value in the cycle of a press event.
- Debounce:
  - Counter cnt has width clog2(DB_CYCLES+1).
  - If synchronised btn equals the debounced level, cnt is cleared to 0.
  - Otherwise cnt increments. When cnt reaches DB_CYCLES-1 while still differing, the debounced level takes the synchronised value and cnt clears.
  - Any glitch shorter than DB_CYCLES cycles produces no level change.
- Press event:
  - A single-cycle internal pulse, raised on the cycle the debounced level goes 1 to 0.
  - Release (0 to 1) is debounced identically but generates no event.
  - Holding the button produces exactly one event.
- Latency: from the first clk edge sampling btn_n low (stable), the capture register updates DB_CYCLES+2 clocks later.
- FSM, acting only on press events (no event = hold state and all outputs):
  - WAIT_A (00): data_a <= sw_sync; go to WAIT_B. valid stays 0.
  - WAIT_B (01): data_b <= sw_sync; valid <= 1; go to SHOW.
  - SHOW (10): data_a <= sw_sync; valid <= 0; go to WAIT_B. data_b keeps its old value until the next capture.
  - Code 11 is unreachable; if entered, return to WAIT_A next cycle with valid = 0.
- Outputs:
  - data_a, data_b and valid are registered; state_led is registered as the state register.
  - data_a and data_b change only in the event cycle and are otherwise stable.
- Arithmetic: none. Operands are passed through unsigned, full WIDTH, with no truncation.
- Reset mid-operation: all state returns to reset values asynchronously. A button held low through reset deassertion produces an event only after it is debounced low (DB_CYCLES+2 cycles after release of reset), because the debounced level restarts at 1.
- Event coinciding with a switch change: the value captured is whatever sw_sync holds in the event cycle. No additional sw filtering is applied.

Test Plan (DB_CYCLES=4 in simulation):
- Reset: assert rst_n=0 mid-cycle -> outputs go to 0 immediately, state_led=00, before the next clk edge.
- Normal pair:
  - Stimulus: sw=4'h5, press 10 cycles, release; then sw=4'hA, press, release.
  - Required: data_a=5 exactly DB_CYCLES+2 clocks after the first press; then data_b=A, valid=1, state_led=10.
  - Downstream sum=F, c_out=0.
- Bounce rejection: btn_n toggling low/high every 2 cycles for 20 cycles, then held high -> no event; state stays 00 and data_a stays 0.
- Hold: btn_n held low for 100 cycles in WAIT_A -> exactly one capture, state=01; no second capture.
- Re-entry from SHOW:
  - Start from SHOW with A=5, B=A; set sw=4'hF and press.
  - Required: data_a=F, valid=0, data_b still A, state_led=01.
  - Then sw=4'h1 and press -> valid=1; downstream sum=0, c_out=1.
- Reset mid-debounce: btn_n low for 2 cycles, then pulse rst_n low; keep btn_n low afterwards -> no capture until DB_CYCLES+2 cycles after rst_n deasserts, then data_a=sw.

Source files
------------

// File: rtl/operand_loader.sv
// Purpose: synchronise and debounce the switches and pushbutton, then capture operands A and B on successive presses.
// Latency: data_a/data_b update DB_CYCLES+2 clocks after the first clk edge that samples a stable press.
// Backpressure: none; operands are held stable until the next press event, and valid marks a completed pair.
module operand_loader #(
  parameter int WIDTH     = 4,
  parameter int DB_CYCLES = 500000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw,
  input  logic             btn_n,
  output logic [WIDTH-1:0] data_a,
  output logic [WIDTH-1:0] data_b,
  output logic             valid,
  output logic [1:0]       state_led
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    WAIT_A = 2'b00,
    WAIT_B = 2'b01,
    SHOW   = 2'b10,
    BAD    = 2'b11
  } state_t;

  logic             btn_meta;
  logic             btn_sync;
  logic [WIDTH-1:0] sw_meta;
  logic [WIDTH-1:0] sw_sync;
  logic [CW-1:0]    cnt;
  logic             db_level;
  logic             db_prev;
  logic             press;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] data_a_nxt;
  logic [WIDTH-1:0] data_b_nxt;
  logic             valid_nxt;

  // Two-flop synchronisers; button idles released (1), switches idle at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_meta <= 1'b1;
      btn_sync <= 1'b1;
      sw_meta  <= '0;
      sw_sync  <= '0;
    end else begin
      btn_meta <= btn_n;
      btn_sync <= btn_meta;
      sw_meta  <= sw;
      sw_sync  <= sw_meta;
    end
  end

  // Debounce: the level follows the synchronised button only after it has differed long enough.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      db_level <= 1'b1;
    end else if (btn_sync == db_level) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      db_level <= btn_sync;
      cnt      <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Delayed debounced level for falling-edge (press) detection; releases generate nothing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_prev <= 1'b1;
    end else begin
      db_prev <= db_level;
    end
  end

  assign press = db_prev & ~db_level;

  // State and operand registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= WAIT_A;
      data_a <= '0;
      data_b <= '0;
      valid  <= 1'b0;
    end else begin
      state  <= state_nxt;
      data_a <= data_a_nxt;
      data_b <= data_b_nxt;
      valid  <= valid_nxt;
    end
  end

  // Next-state and capture decisions; without a press everything holds.
  always_comb begin
    state_nxt  = state;
    data_a_nxt = data_a;
    data_b_nxt = data_b;
    valid_nxt  = valid;
    case (state)
      WAIT_A: begin
        if (press) begin
          data_a_nxt = sw_sync;
          state_nxt  = WAIT_B;
        end
      end
      WAIT_B: begin
        if (press) begin
          data_b_nxt = sw_sync;
          valid_nxt  = 1'b1;
          state_nxt  = SHOW;
        end
      end
      SHOW: begin
        if (press) begin
          data_a_nxt = sw_sync;
          valid_nxt  = 1'b0;
          state_nxt  = WAIT_B;
        end
      end
      default: begin
        // Unreachable encoding: recover to a clean start.
        valid_nxt = 1'b0;
        state_nxt = WAIT_A;
      end
    endcase
  end

  assign state_led = state;

endmodule

// File: tb/tb_operand_loader.sv
module tb_operand_loader;

  localparam int W  = 4;
  localparam int DB = 4;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] sw;
  logic         btn_n;
  logic [W-1:0] data_a;
  logic [W-1:0] data_b;
  logic         valid;
  logic [1:0]   state_led;

  int total;
  int bad;

  logic [W-1:0] presses[$];

  operand_loader #(.WIDTH(W), .DB_CYCLES(DB)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sw(sw),
    .btn_n(btn_n),
    .data_a(data_a),
    .data_b(data_b),
    .valid(valid),
    .state_led(state_led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Clean press of given length with operand value v, followed by a settled release.
  task automatic press(input logic [W-1:0] v, input int hold);
    sw = v;
    tick(3);
    btn_n = 1'b0;
    tick(hold);
    btn_n = 1'b1;
    tick(DB + 6);
  endtask

  task automatic check_sum(input string tag, input logic [3:0] s_exp, input logic c_exp);
    logic [W:0] s;
    s = {1'b0, data_a} + {1'b0, data_b};
    check_eq({tag, "_sum"}, 32'(s[W-1:0]), 32'(s_exp));
    check_eq({tag, "_cout"}, 32'(s[W]), 32'(c_exp));
  endtask

  // Transaction-level reference: outputs follow from the ordered list of accepted presses.
  task automatic check_model(input string tag);
    int n;
    logic [W-1:0] ea;
    logic [W-1:0] eb;
    logic ev;
    logic [1:0] es;
    n  = presses.size();
    ea = (n == 0) ? '0 : presses[((n - 1) / 2) * 2];
    eb = (n < 2) ? '0 : presses[(n / 2) * 2 - 1];
    ev = (n > 0) && (n % 2 == 0);
    es = (n == 0) ? 2'b00 : ((n % 2 == 1) ? 2'b01 : 2'b10);
    check_eq({tag, "_a"}, 32'(data_a), 32'(ea));
    check_eq({tag, "_b"}, 32'(data_b), 32'(eb));
    check_eq({tag, "_valid"}, 32'(valid), 32'(ev));
    check_eq({tag, "_state"}, 32'(state_led), 32'(es));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    sw    = '0;
    btn_n = 1'b1;
    tick(3);
    check_eq("rst_a", 32'(data_a), 32'h0);
    check_eq("rst_b", 32'(data_b), 32'h0);
    check_eq("rst_valid", 32'(valid), 32'h0);
    check_eq("rst_state", 32'(state_led), 32'h0);
    rst_n = 1'b1;
    tick(2);

    // Bounce rejection: 2-cycle low/high toggling never debounces.
    sw = 4'h9;
    tick(3);
    for (int i = 0; i < 10; i++) begin
      btn_n = ~btn_n;
      tick(2);
    end
    btn_n = 1'b1;
    tick(DB + 8);
    check_eq("bounce_state", 32'(state_led), 32'h0);
    check_eq("bounce_a", 32'(data_a), 32'h0);

    // Hold: one long press gives exactly one capture even if switches move.
    sw = 4'h3;
    tick(3);
    btn_n = 1'b0;
    tick(20);
    check_eq("hold_a1", 32'(data_a), 32'h3);
    check_eq("hold_state1", 32'(state_led), 32'h1);
    sw = 4'h7;
    tick(80);
    check_eq("hold_a2", 32'(data_a), 32'h3);
    check_eq("hold_b2", 32'(data_b), 32'h0);
    check_eq("hold_state2", 32'(state_led), 32'h1);
    btn_n = 1'b1;
    tick(DB + 6);

    // Asynchronous reset mid-cycle, checked before the next rising edge.
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_a", 32'(data_a), 32'h0);
    check_eq("arst_valid", 32'(valid), 32'h0);
    check_eq("arst_state", 32'(state_led), 32'h0);
    tick(1);
    rst_n = 1'b1;
    tick(2);

    // Normal pair with exact capture latency.
    sw = 4'h5;
    tick(3);
    btn_n = 1'b0;
    tick(DB + 2);
    check_eq("lat_before", 32'(data_a), 32'h0);
    tick(1);
    check_eq("lat_at", 32'(data_a), 32'h5);
    check_eq("lat_state", 32'(state_led), 32'h1);
    tick(10 - (DB + 3));
    btn_n = 1'b1;
    tick(DB + 6);
    press(4'hA, 10);
    check_eq("pair_a", 32'(data_a), 32'h5);
    check_eq("pair_b", 32'(data_b), 32'hA);
    check_eq("pair_valid", 32'(valid), 32'h1);
    check_eq("pair_state", 32'(state_led), 32'h2);
    check_sum("pair", 4'hF, 1'b0);

    // Re-entry from SHOW.
    press(4'hF, 10);
    check_eq("reent_a", 32'(data_a), 32'hF);
    check_eq("reent_b", 32'(data_b), 32'hA);
    check_eq("reent_valid", 32'(valid), 32'h0);
    check_eq("reent_state", 32'(state_led), 32'h1);
    press(4'h1, 10);
    check_eq("reent2_valid", 32'(valid), 32'h1);
    check_eq("reent2_state", 32'(state_led), 32'h2);
    check_sum("reent2", 4'h0, 1'b1);

    // Reset mid-debounce with the button held low through reset release.
    sw = 4'hC;
    tick(3);
    btn_n = 1'b0;
    tick(2);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(DB + 2);
    check_eq("rstdb_before", 32'(data_a), 32'h0);
    check_eq("rstdb_state0", 32'(state_led), 32'h0);
    tick(1);
    check_eq("rstdb_a", 32'(data_a), 32'hC);
    check_eq("rstdb_state", 32'(state_led), 32'h1);
    btn_n = 1'b1;
    tick(DB + 6);

    // Randomised presses with bounce, compared against the press-list model.
    do_reset();
    presses.delete();
    check_model("rnd_init");
    for (int p = 0; p < 12; p++) begin
      logic [W-1:0] v;
      int ng;
      v  = W'($urandom_range(0, 15));
      sw = v;
      tick(3);
      ng = $urandom_range(0, 2);
      for (int g = 0; g < ng; g++) begin
        btn_n = 1'b0;
        tick($urandom_range(1, 3));
        btn_n = 1'b1;
        tick($urandom_range(1, 3));
      end
      btn_n = 1'b0;
      tick($urandom_range(6, 15));
      btn_n = 1'b1;
      tick($urandom_range(1, 3));
      btn_n = 1'b0;
      tick($urandom_range(1, 3));
      btn_n = 1'b1;
      tick(DB + 8);
      presses.push_back(v);
      check_model($sformatf("rnd%0d", p));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
